steps_seg_display: RTL and testbench

//  Consumes the step counter and finish flag produced by the maze game logic and drives the 4-digit

---
 rtl/maze_pkg.sv | 43 ++++
 rtl/bin2bcd_seq.sv | 68 ++++++
 rtl/steps_seg_display.sv | 116 +++++++++++
 tb/tb_steps_seg_display.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze game display path: segment codes, digit count,
// saturation limit, conversion FSM states and the BCD-to-seven-segment decoder.
package maze_pkg;

  localparam int          NUM_DIGITS    = 4;
  localparam logic [15:0] STEPS_MAX_BCD = 16'd9999;

  // Cathode codes are {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7 = SEG_0;
      4'd1:    seg7 = SEG_1;
      4'd2:    seg7 = SEG_2;
      4'd3:    seg7 = SEG_3;
      4'd4:    seg7 = SEG_4;
      4'd5:    seg7 = SEG_5;
      4'd6:    seg7 = SEG_6;
      4'd7:    seg7 = SEG_7;
      4'd8:    seg7 = SEG_8;
      4'd9:    seg7 = SEG_9;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: loads on start, one add-3/shift per cycle for 16 cycles,
// then publishes the four BCD digits in DONE.
module bin2bcd_seq
  import maze_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  conv_state_t state;
  logic [31:0] shift;
  logic [4:0]  iter;

  // Upper 16 bits hold the BCD digits being built, lower 16 the remaining binary bits
  function automatic logic [31:0] dabble_step(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (t[16 + 4*d +: 4] >= 4'd5)
        t[16 + 4*d +: 4] = t[16 + 4*d +: 4] + 4'd3;
    end
    return {t[30:0], 1'b0};
  endfunction

  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      shift <= '0;
      iter  <= '0;
      busy  <= 1'b0;
      bcd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift <= {16'd0, bin};
            iter  <= '0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          shift <= dabble_step(shift);
          iter  <= iter + 5'd1;
          if (iter == 5'd15)
            state <= DONE;
        end
        DONE: begin
          bcd   <= shift[31:16];
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/steps_seg_display.sv
// Step-count display: captures and saturates the step count, converts it to BCD,
// and scans it onto a 4-digit multiplexed seven-segment display with blanking and blink.
module steps_seg_display
  import maze_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] steps,
  input  logic        finish,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  logic [15:0]   last_steps;
  logic          ovf_nxt;
  logic          ovf_q;
  logic [15:0]   bcd_q;
  logic          start;
  logic          done;
  logic [15:0]   sat_steps;
  logic [RW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;
  logic [3:0]    cur_digit;
  logic [3:0]    lead_blank;

  // A new value is only taken while the converter is idle; changes during a conversion wait
  assign start     = !busy && (steps != last_steps);
  assign sat_steps = (steps > STEPS_MAX_BCD) ? STEPS_MAX_BCD : steps;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (sat_steps),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_steps <= '0;
      ovf_nxt    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (start) begin
        last_steps <= steps;
        ovf_nxt    <= (steps > STEPS_MAX_BCD);
      end
      if (done)
        ovf_q <= ovf_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!finish) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // A digit is a leading zero when it and every more-significant digit are zero
  always_comb begin
    cur_digit     = bcd_q[4*digit_idx +: 4];
    lead_blank    = 4'b0000;
    lead_blank[3] = (bcd_q[15:12] == 4'd0);
    lead_blank[2] = lead_blank[3] && (bcd_q[11:8] == 4'd0);
    lead_blank[1] = lead_blank[2] && (bcd_q[7:4] == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= blink_on ? ~(4'b0001 << digit_idx) : 4'b1111;
      seg <= (BLANK_LZ && lead_blank[digit_idx]) ? SEG_BLANK : seg7(cur_digit);
      dp  <= ~ovf_q;
    end
  end

endmodule

// File: tb/tb_steps_seg_display.sv
// Directed bench for steps_seg_display with fast dividers (REFRESH_DIV=4, BLINK_DIV=8);
// every expected value below is a hand-computed constant.
module tb_steps_seg_display;

  logic        clk;
  logic        reset;
  logic [15:0] steps;
  logic        finish;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;

  int vectors;
  int miscompares;

  logic [6:0] scan_seg [4];
  logic       scan_dp  [4];
  logic [3:0] scan_seen;

  localparam logic [6:0] S_BLANK = 7'b1111111;

  steps_seg_display #(
    .REFRESH_DIV (4),
    .BLINK_DIV   (8),
    .BLANK_LZ    (1'b1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .steps  (steps),
    .finish (finish),
    .an     (an),
    .seg    (seg),
    .dp     (dp),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Records seg/dp seen on each anode over more than one full scan period
  task automatic scan_display();
    scan_seen = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      scan_seg[k] = 7'bx;
      scan_dp[k]  = 1'bx;
    end
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (an == ~(4'b0001 << k)) begin
          scan_seen[k] = 1'b1;
          scan_seg[k]  = seg;
          scan_dp[k]   = dp;
        end
      end
    end
  endtask

  // Waits (bounded) for busy to rise, then counts the cycles it stays high
  task automatic measure_busy(output int n);
    int guard;
    n = 0;
    guard = 0;
    while (!busy && guard < 4) begin
      @(negedge clk);
      guard++;
    end
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int hi;
    logic [6:0] exp_seg [4];
    exp_seg = '{7'b1000000, S_BLANK, S_BLANK, S_BLANK};
    reset = 1'b0;
    steps = 16'd0;
    finish = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (an !== 4'b1111) begin miscompares++; $display("[TB] FAIL reset_an: got %b expected 1111", an); end
    vectors++; if (seg !== 7'b1111111) begin miscompares++; $display("[TB] FAIL reset_seg: got %b expected 1111111", seg); end
    vectors++; if (dp !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_dp: got %b expected 1", dp); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (an !== 4'b1110) begin miscompares++; $display("[TB] FAIL release_an: got %b expected 1110", an); end
    vectors++; if (seg !== 7'b1000000) begin miscompares++; $display("[TB] FAIL release_seg: got %b expected 1000000", seg); end
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) hi++;
      @(negedge clk);
    end
    vectors++; if (hi != 0) begin miscompares++; $display("[TB] FAIL idle_busy: got %0d busy cycles expected 0", hi); end
    scan_display();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (!scan_seen[k] || scan_seg[k] !== exp_seg[k] || scan_dp[k] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL reset_digit%0d: got seen=%b seg=%b dp=%b expected seg=%b dp=1", k, scan_seen[k], scan_seg[k], scan_dp[k], exp_seg[k]);
      end
    end
  endtask

  task automatic test_conv_1234();
    int n;
    logic [6:0] exp_seg [4];
    exp_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    steps = 16'd1234;
    measure_busy(n);
    vectors++; if (n != 17) begin miscompares++; $display("[TB] FAIL conv1234_busy: got %0d cycles expected 17", n); end
    scan_display();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (!scan_seen[k] || scan_seg[k] !== exp_seg[k] || scan_dp[k] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL conv1234_digit%0d: got seen=%b seg=%b dp=%b expected seg=%b dp=1", k, scan_seen[k], scan_seg[k], scan_dp[k], exp_seg[k]);
      end
    end
  endtask

  task automatic test_blank_12();
    int n;
    logic [6:0] exp_seg [4];
    exp_seg = '{7'b0100100, 7'b1111001, S_BLANK, S_BLANK};
    steps = 16'd12;
    measure_busy(n);
    vectors++; if (n != 17) begin miscompares++; $display("[TB] FAIL conv12_busy: got %0d cycles expected 17", n); end
    scan_display();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (!scan_seen[k] || scan_seg[k] !== exp_seg[k] || scan_dp[k] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL conv12_digit%0d: got seen=%b seg=%b dp=%b expected seg=%b dp=1", k, scan_seen[k], scan_seg[k], scan_dp[k], exp_seg[k]);
      end
    end
  endtask

  task automatic test_saturation();
    int n;
    logic [6:0] exp_seg [4];
    steps = 16'd12345;
    measure_busy(n);
    vectors++; if (n != 17) begin miscompares++; $display("[TB] FAIL sat_busy: got %0d cycles expected 17", n); end
    scan_display();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (!scan_seen[k] || scan_seg[k] !== 7'b0010000 || scan_dp[k] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL sat_digit%0d: got seen=%b seg=%b dp=%b expected seg=0010000 dp=0", k, scan_seen[k], scan_seg[k], scan_dp[k]);
      end
    end
    exp_seg = '{7'b1111000, S_BLANK, S_BLANK, S_BLANK};
    steps = 16'd7;
    measure_busy(n);
    vectors++; if (n != 17) begin miscompares++; $display("[TB] FAIL after_sat_busy: got %0d cycles expected 17", n); end
    scan_display();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (!scan_seen[k] || scan_seg[k] !== exp_seg[k] || scan_dp[k] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL after_sat_digit%0d: got seen=%b seg=%b dp=%b expected seg=%b dp=1", k, scan_seen[k], scan_seg[k], scan_dp[k], exp_seg[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int n2;
    logic       d0_seen;
    logic [6:0] d0_seg;
    logic [6:0] exp_seg [4];
    exp_seg = '{7'b0000010, S_BLANK, S_BLANK, S_BLANK};
    steps = 16'd5;
    @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_capture: got busy=%b expected 1", busy); end
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 3) steps = 16'd6;
      @(negedge clk);
    end
    vectors++; if (n != 17) begin miscompares++; $display("[TB] FAIL b2b_first_busy: got %0d cycles expected 17", n); end
    @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_recapture: got busy=%b expected 1", busy); end
    // The first result (5) stays on display throughout the recapture
    d0_seen = 1'b0;
    d0_seg = 7'bx;
    n2 = 0;
    while (busy && n2 < 40) begin
      if (an == 4'b1110) begin
        d0_seen = 1'b1;
        d0_seg = seg;
      end
      n2++;
      @(negedge clk);
    end
    vectors++; if (n2 != 17) begin miscompares++; $display("[TB] FAIL b2b_second_busy: got %0d cycles expected 17", n2); end
    vectors++; if (!d0_seen || d0_seg !== 7'b0010010) begin miscompares++; $display("[TB] FAIL b2b_shows5: got seen=%b seg=%b expected 0010010", d0_seen, d0_seg); end
    scan_display();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (!scan_seen[k] || scan_seg[k] !== exp_seg[k] || scan_dp[k] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL b2b_digit%0d: got seen=%b seg=%b dp=%b expected seg=%b dp=1", k, scan_seen[k], scan_seg[k], scan_dp[k], exp_seg[k]);
      end
    end
  endtask

  task automatic test_blink();
    int off;
    int run;
    int max_run;
    finish = 1'b1;
    repeat (2) @(negedge clk);
    off = 0;
    run = 0;
    max_run = 0;
    for (int i = 0; i < 32; i++) begin
      if (an == 4'b1111) begin
        off++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      @(negedge clk);
    end
    vectors++; if (off != 16) begin miscompares++; $display("[TB] FAIL blink_off_count: got %0d expected 16", off); end
    vectors++; if (max_run != 8) begin miscompares++; $display("[TB] FAIL blink_off_run: got %0d expected 8", max_run); end
    finish = 1'b0;
    @(negedge clk);
    off = 0;
    for (int i = 0; i < 8; i++) begin
      if (an == 4'b1111) off++;
      @(negedge clk);
    end
    vectors++; if (off != 0) begin miscompares++; $display("[TB] FAIL blink_stop: got %0d dark cycles expected 0", off); end
  endtask

  task automatic test_reset_mid_conv();
    int hi;
    logic [6:0] exp_seg [4];
    exp_seg = '{7'b1000000, S_BLANK, S_BLANK, S_BLANK};
    steps = 16'd4321;
    repeat (5) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL midconv_busy: got %b expected 1", busy); end
    reset = 1'b0;
    steps = 16'd0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midconv_abort: got busy=%b expected 0", busy); end
    vectors++; if (an !== 4'b1111) begin miscompares++; $display("[TB] FAIL midconv_an: got %b expected 1111", an); end
    @(negedge clk);
    reset = 1'b1;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) hi++;
    end
    vectors++; if (hi != 0) begin miscompares++; $display("[TB] FAIL midconv_idle: got %0d busy cycles expected 0", hi); end
    scan_display();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (!scan_seen[k] || scan_seg[k] !== exp_seg[k] || scan_dp[k] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL midconv_digit%0d: got seen=%b seg=%b dp=%b expected seg=%b dp=1", k, scan_seen[k], scan_seg[k], scan_dp[k], exp_seg[k]);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    steps = 16'd0;
    finish = 1'b0;
    test_reset();
    test_conv_1234();
    test_blank_12();
    test_saturation();
    test_back_to_back();
    test_blink();
    test_reset_mid_conv();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
